// File: rtl/ball_pkg.sv
// Shared types and defaults for the ball motion engine and its peer hand-off payload.
package ball_pkg;

  localparam int DEF_SERVE_Y     = 220;
  localparam int DEF_BASE_PERIOD = 270000;
  localparam int VY_INIT         = -3;
  localparam int PL_CNT_W        = 20;
  localparam int PL_VEL_W        = 8;
  localparam int PL_GRAV_W       = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN_R   = 3'd1,
    DIVIDE  = 3'd2,
    RUN_L   = 3'd3,
    HANDOFF = 3'd4,
    OVER    = 3'd5
  } state_t;

  typedef struct packed {
    logic [9:0]                  y;
    logic signed [PL_VEL_W-1:0]  vy;
    logic [PL_GRAV_W-1:0]        grav;
    logic [PL_CNT_W-1:0]         period;
  } ball_payload_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock; the first bit is resolved in the start cycle.
module seq_divider #(
  parameter int W = 20
) (
  input  logic         clk_25MHZ,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem, q, rem_in, q_in, rem_nx, q_nx;
  logic [W+1:0]  trial;
  logic [CW-1:0] cnt;

  always_comb begin
    rem_in = start ? '0 : rem;
    q_in   = start ? num : q;
    trial  = {1'b0, rem_in, q_in[W-1]} - {2'b00, den};
    if (!trial[W+1]) begin
      rem_nx = trial[W-1:0];
      q_nx   = {q_in[W-2:0], 1'b1};
    end else begin
      rem_nx = {rem_in[W-2:0], q_in[W-1]};
      q_nx   = {q_in[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_25MHZ) begin
    if (reset) begin
      rem  <= '0;
      q    <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem <= rem_nx;
        q   <= q_nx;
        cnt <= CW'(W - 1);
      end else if (cnt != '0) begin
        rem  <= rem_nx;
        q    <= q_nx;
        cnt  <= cnt - 1'b1;
        done <= (cnt == CW'(1));
      end
    end
  end

  assign busy = (cnt != '0);
  assign quot = q;

endmodule

// File: rtl/ball_motion_engine.sv
// Ball physics and game FSM for one board: stepping, gravity, wall bounce, peer hand-off
// and post-hit step period recomputation.
module ball_motion_engine
  import ball_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 20,
  parameter int X_STEP      = 10,
  parameter int GRAV_PERIOD = 4,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int CNT_W       = PL_CNT_W,
  parameter int VEL_W       = PL_VEL_W,
  parameter int SERVE_Y     = DEF_SERVE_Y
) (
  input  logic                             clk_25MHZ,
  input  logic                             reset,
  input  logic                             upscale,
  input  logic                             game_start,
  input  logic                             collision_detected,
  input  logic [9:0]                       estimated_speed,
  input  logic                             rx_valid,
  output logic                             rx_ready,
  input  logic [9:0]                       rx_y,
  input  logic signed [VEL_W-1:0]          rx_vy,
  input  logic [$clog2(GRAV_PERIOD)-1:0]   rx_grav,
  input  logic [CNT_W-1:0]                 rx_period,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic [9:0]                       tx_y,
  output logic signed [VEL_W-1:0]          tx_vy,
  output logic [$clog2(GRAV_PERIOD)-1:0]   tx_grav,
  output logic [CNT_W-1:0]                 tx_period,
  output logic [9:0]                       ball_x,
  output logic [9:0]                       ball_y,
  output logic                             moving_right,
  output logic                             game_over,
  output logic [2:0]                       state_o
);

  localparam int GW = $clog2(GRAV_PERIOD);
  localparam logic signed [VEL_W:0] VMAX = (VEL_W+1)'((1 << (VEL_W - 1)) - 1);

  state_t                  state;
  logic [9:0]              x, y;
  logic signed [VEL_W-1:0] vy;
  logic [GW-1:0]           grav;
  logic [CNT_W-1:0]        period, tick;
  ball_payload_t           tx_pl, rx_pl;

  logic [9:0]              x_lim, y_max, y_step;
  logic signed [VEL_W:0]   vy_ext, vy_inc, vy_nxt, vy_neg;
  logic signed [VEL_W-1:0] vy_step;
  logic [GW-1:0]           grav_nxt;
  logic signed [10:0]      y_sum;
  logic                    step_now;

  logic                    div_start, div_busy, div_done;
  logic [CNT_W-1:0]        div_den, div_quot;

  assign rx_pl = '{y: rx_y, vy: rx_vy, grav: rx_grav, period: rx_period};

  always_comb begin
    x_lim    = upscale ? 10'(H_RES - BALL_SIZE) : 10'(H_RES / 2 - BALL_SIZE);
    y_max    = upscale ? 10'(V_RES - 1)         : 10'(V_RES / 2 - 1);
    step_now = (tick == period - 1'b1);
    vy_ext   = {vy[VEL_W-1], vy};
    if (grav == GW'(GRAV_PERIOD - 1)) begin
      vy_inc   = vy_ext + (VEL_W+1)'(1);
      grav_nxt = '0;
    end else begin
      vy_inc   = vy_ext;
      grav_nxt = grav + 1'b1;
    end
    if (vy_inc > VMAX)       vy_nxt = VMAX;
    else if (vy_inc < -VMAX) vy_nxt = -VMAX;
    else                     vy_nxt = vy_inc;
    vy_neg = -vy_nxt;
    // Position integrates the pre-gravity velocity; walls reflect the post-gravity one.
    y_sum = $signed({1'b0, y}) + $signed({{(11 - VEL_W){vy[VEL_W-1]}}, vy});
    if (y_sum >= $signed({1'b0, y_max})) begin
      y_step  = y_max;
      vy_step = vy_neg[VEL_W-1:0];
    end else if (y_sum <= 11'sd0) begin
      y_step  = '0;
      vy_step = vy_neg[VEL_W-1:0];
    end else begin
      y_step  = y_sum[9:0];
      vy_step = vy_nxt[VEL_W-1:0];
    end
  end

  assign div_start = (state == RUN_L) && collision_detected;
  assign div_den   = (estimated_speed < 10'd2) ? CNT_W'(2) : CNT_W'(estimated_speed);

  seq_divider #(.W(CNT_W)) u_div (
    .clk_25MHZ (clk_25MHZ),
    .reset     (reset),
    .start     (div_start),
    .num       (CNT_W'(BASE_PERIOD)),
    .den       (div_den),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot)
  );

  always_ff @(posedge clk_25MHZ) begin
    if (reset) begin
      state    <= IDLE;
      x        <= '0;
      y        <= 10'(SERVE_Y);
      vy       <= VEL_W'(VY_INIT);
      grav     <= '0;
      period   <= CNT_W'(BASE_PERIOD);
      tick     <= '0;
      tx_valid <= 1'b0;
      tx_pl    <= '0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (game_start) begin
            state  <= RUN_R;
            x      <= '0;
            y      <= 10'(SERVE_Y);
            vy     <= VEL_W'(VY_INIT);
            grav   <= '0;
            period <= CNT_W'(BASE_PERIOD);
            tick   <= '0;
          end else if (state == IDLE && rx_valid) begin
            state  <= RUN_L;
            x      <= 10'(BALL_SIZE);
            y      <= rx_pl.y;
            vy     <= rx_pl.vy;
            grav   <= rx_pl.grav;
            period <= (rx_pl.period == '0) ? CNT_W'(BASE_PERIOD) : rx_pl.period;
            tick   <= '0;
          end
        end
        RUN_R: begin
          if (step_now) begin
            tick <= '0;
            if (x >= x_lim) begin
              tx_pl    <= '{y: y, vy: vy, grav: grav, period: period};
              tx_valid <= 1'b1;
              state    <= HANDOFF;
            end else begin
              x    <= x + 10'(X_STEP);
              y    <= y_step;
              vy   <= vy_step;
              grav <= grav_nxt;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        RUN_L: begin
          if (collision_detected) begin
            tick  <= '0;
            state <= DIVIDE;
          end else if (step_now) begin
            tick <= '0;
            if (x == '0) begin
              state <= OVER;
            end else begin
              x    <= (x < 10'(X_STEP)) ? '0 : x - 10'(X_STEP);
              y    <= y_step;
              vy   <= vy_step;
              grav <= grav_nxt;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DIVIDE: begin
          if (div_done && !div_busy) begin
            period <= (div_quot == '0) ? CNT_W'(1) : div_quot;
            tick   <= '0;
            state  <= RUN_R;
          end
        end
        HANDOFF: begin
          // A new serve abandons a hand-off the peer never took.
          if (game_start || tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_ready     = (state == IDLE) && !game_start;
  assign tx_y         = tx_pl.y;
  assign tx_vy        = tx_pl.vy;
  assign tx_grav      = tx_pl.grav;
  assign tx_period    = tx_pl.period;
  assign ball_x       = x;
  assign ball_y       = y;
  assign moving_right = (state == RUN_R) || (state == DIVIDE);
  assign game_over    = (state == OVER);
  assign state_o      = state;

endmodule
